// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO types and default geometry
// Contents: fifo_mode_e (read-port timing mode), default data/address widths,
//           mode_of() maps an integer FWFT parameter onto fifo_mode_e.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,   // registered rdata, one cycle after an accepted pop
        FIFO_FWFT = 1'b1    // head word presented combinationally while not empty
    } fifo_mode_e;

    localparam int FIFO_DSIZE = 8;
    localparam int FIFO_ASIZE = 4;

    function automatic fifo_mode_e mode_of(input int fwft);
        return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
    endfunction

endpackage

// File: rtl/fifomem.sv
// rtl/fifomem.sv - FIFO storage array, synchronous write, asynchronous read
// Ports:
//   wclk    in   1      write clock
//   wclken  in   1      write request
//   wfull   in   1      blocks the write while the FIFO is full
//   waddr   in   ASIZE  write address
//   raddr   in   ASIZE  read address
//   wdata   in   DSIZE  write data
//   rdata   out  DSIZE  mem[raddr], combinational
module fifomem
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE,
    parameter int ASIZE = FIFO_ASIZE
) (
    input  logic             wclk,
    input  logic             wclken,
    input  logic             wfull,
    input  logic [ASIZE-1:0] waddr,
    input  logic [ASIZE-1:0] raddr,
    input  logic [DSIZE-1:0] wdata,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ASIZE;

    // Contents are deliberately not reset; pointers define what is valid.
    logic [DSIZE-1:0] mem [DEPTH];

    assign rdata = mem[raddr];

    always_ff @(posedge wclk) begin
        if (wclken && !wfull) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/sync_fifo_thresh.sv
// rtl/sync_fifo_thresh.sv - single-clock FIFO with occupancy count, thresholds, FWFT option, sticky errors
// Ports:
//   clk           in   1        clock, all state on rising edge
//   rst           in   1        asynchronous reset, active-high
//   wdata         in   DSIZE    write data
//   winc          in   1        push request, accepted when !wfull
//   rinc          in   1        pop request, accepted when !rempty
//   clr_err       in   1        clears overflow/underflow (a new error in the same cycle wins)
//   rdata         out  DSIZE    read data, registered (STD) or head-of-queue (FWFT)
//   wfull         out  1        FIFO holds 2**ASIZE words
//   rempty        out  1        FIFO holds no words
//   almost_full   out  1        count >= AFULL_THR
//   almost_empty  out  1        count <= AEMPTY_THR
//   count         out  ASIZE+1  occupancy
//   overflow      out  1        sticky, push attempted while full
//   underflow     out  1        sticky, pop attempted while empty
module sync_fifo_thresh
    import fifo_pkg::*;
#(
    parameter int DSIZE      = FIFO_DSIZE,
    parameter int ASIZE      = FIFO_ASIZE,
    parameter int FWFT       = 0,
    parameter int AFULL_THR  = 12,
    parameter int AEMPTY_THR = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             clr_err,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int             DEPTH      = 1 << ASIZE;
    localparam fifo_mode_e     MODE       = mode_of(FWFT);
    localparam logic [ASIZE:0] AFULL_LVL  = AFULL_THR[ASIZE:0];
    localparam logic [ASIZE:0] AEMPTY_LVL = AEMPTY_THR[ASIZE:0];
    localparam logic [ASIZE:0] ONE        = {{ASIZE{1'b0}}, 1'b1};

    if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull_thr
        $error("sync_fifo_thresh: AFULL_THR=%0d outside 1..%0d", AFULL_THR, DEPTH);
    end
    if (AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1) begin : g_bad_aempty_thr
        $error("sync_fifo_thresh: AEMPTY_THR=%0d outside 0..%0d", AEMPTY_THR, DEPTH - 1);
    end

    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic [ASIZE:0]   count_q;
    logic [DSIZE-1:0] mem_rdata;
    logic [DSIZE-1:0] rdata_q;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // with equal low-order addresses.
    assign wfull  = (wptr[ASIZE] != rptr[ASIZE]) &&
                    (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
    assign rempty = (wptr == rptr);

    // Acceptance is decided from registered flags only, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign push_ok = winc && !wfull;
    assign pop_ok  = rinc && !rempty;

    assign count        = count_q;
    assign almost_full  = (count_q >= AFULL_LVL);
    assign almost_empty = (count_q <= AEMPTY_LVL);

    fifomem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .wclk   (clk),
        .wclken (winc),
        .wfull  (wfull),
        .waddr  (wptr[ASIZE-1:0]),
        .raddr  (rptr[ASIZE-1:0]),
        .wdata  (wdata),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count_q   <= '0;
            rdata_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + ONE;
            end
            if (pop_ok) begin
                rptr    <= rptr + ONE;
                rdata_q <= mem_rdata;
            end

            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase

            if (winc && wfull) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end

            if (rinc && rempty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    // In FWFT mode the head word is shown directly; once empty, the last
    // popped word (or the reset value) is held so rdata never floats.
    if (MODE == FIFO_FWFT) begin : g_fwft
        assign rdata = rempty ? rdata_q : mem_rdata;
    end else begin : g_std
        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// tb/tb_sync_fifo_thresh.sv - scoreboard bench for sync_fifo_thresh in STD and FWFT modes
module tb_sync_fifo_thresh;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc;
    logic       rinc;
    logic       clr_err;
    logic [7:0] wdata;

    logic [7:0] rdata_s, rdata_f;
    logic       wfull_s, wfull_f;
    logic       rempty_s, rempty_f;
    logic       af_s, af_f;
    logic       ae_s, ae_f;
    logic [2:0] count_s, count_f;
    logic       ovf_s, ovf_f;
    logic       unf_s, unf_f;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_q[$];     // words the FIFO should currently hold
    logic [7:0] exp_q[$];   // words the STD port owes after accepted pops
    logic       pop_fire;

    always #5 clk = ~clk;

    sync_fifo_thresh #(
        .DSIZE(8), .ASIZE(2), .FWFT(0), .AFULL_THR(3), .AEMPTY_THR(1)
    ) dut_s (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .clr_err(clr_err),
        .rdata(rdata_s), .wfull(wfull_s), .rempty(rempty_s), .almost_full(af_s),
        .almost_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s)
    );

    sync_fifo_thresh #(
        .DSIZE(8), .ASIZE(2), .FWFT(1), .AFULL_THR(3), .AEMPTY_THR(1)
    ) dut_f (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .clr_err(clr_err),
        .rdata(rdata_f), .wfull(wfull_f), .rempty(rempty_f), .almost_full(af_f),
        .almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(unf_f)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Packed as {count, wfull, rempty, almost_full, almost_empty, overflow, underflow}
    task automatic chk_state(input string tag, input logic [2:0] cnt, input logic full,
                             input logic empty, input logic af, input logic ae,
                             input logic ovf, input logic unf);
        logic [8:0] exp_v;
        exp_v = {cnt, full, empty, af, ae, ovf, unf};
        chk({tag, "_std_state"}, 32'({count_s, wfull_s, rempty_s, af_s, ae_s, ovf_s, unf_s}), 32'(exp_v));
        chk({tag, "_fwft_state"}, 32'({count_f, wfull_f, rempty_f, af_f, ae_f, ovf_f, unf_f}), 32'(exp_v));
    endtask

    // Drive one cycle of stimulus, record expectations, return after the edge has settled.
    task automatic op(input logic w, input logic [7:0] d, input logic r, input logic c);
        bit push_acc;
        bit pop_acc;
        winc    = w;
        wdata   = d;
        rinc    = r;
        clr_err = c;
        push_acc = w && (m_q.size() < 4);
        pop_acc  = r && (m_q.size() > 0);
        if (pop_acc) exp_q.push_back(m_q.pop_front());
        if (push_acc) m_q.push_back(d);
        @(negedge clk);
        #2;
        winc    = 1'b0;
        rinc    = 1'b0;
        clr_err = 1'b0;
    endtask

    // Monitor: STD port presents data one cycle after an accepted pop handshake.
    always @(posedge clk or posedge rst) begin
        if (rst) pop_fire <= 1'b0;
        else     pop_fire <= rinc && !rempty_s;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst) begin
            if (pop_fire) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL std_rdata_unexpected: got 0x%0h, expected no output", rdata_s);
                end else begin
                    e = exp_q.pop_front();
                    chk("std_rdata", 32'(rdata_s), 32'(e));
                end
            end
            if (!rempty_f) begin
                if (m_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL fwft_rdata_unexpected: got 0x%0h, expected empty", rdata_f);
                end else begin
                    e = m_q[0];
                    chk("fwft_rdata", 32'(rdata_f), 32'(e));
                end
            end
        end
    end

    logic [7:0] fill_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] fill_b [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
    // Expected {wfull, almost_full, almost_empty} after each of four pushes from empty
    logic [2:0] fill_flags [4] = '{3'b001, 3'b000, 3'b010, 3'b110};
    // Expected {rempty, almost_full, almost_empty} after each of four pops from full
    logic [2:0] drain_flags [4] = '{3'b010, 3'b000, 3'b001, 3'b101};

    initial begin
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = 8'h00;
        repeat (2) @(negedge clk);
        #2;
        chk_state("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset_rdata_std", 32'(rdata_s), 32'h0);
        chk("reset_rdata_fwft", 32'(rdata_f), 32'h0);
        rst = 1'b0;

        op(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("pop_empty", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        op(1'b1, 8'h01, 1'b0, 1'b0);
        op(1'b1, 8'h02, 1'b0, 1'b0);
        op(1'b1, 8'h03, 1'b0, 1'b0);
        chk_state("pre_rst", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        rst = 1'b1;
        #1;
        chk_state("mid_rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("mid_rst_rdata_std", 32'(rdata_s), 32'h0);
        chk("mid_rst_rdata_fwft", 32'(rdata_f), 32'h0);
        m_q.delete();
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            op(1'b1, fill_a[i], 1'b0, 1'b0);
            chk_state("fill", 3'(i + 1), fill_flags[i][2], 1'b0, fill_flags[i][1],
                      fill_flags[i][0], 1'b0, 1'b0);
        end
        op(1'b1, 8'h55, 1'b0, 1'b0);
        chk_state("overflow", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            op(1'b0, 8'h00, 1'b1, 1'b0);
            chk_state("drain", 3'(3 - i), 1'b0, drain_flags[i][2], drain_flags[i][1],
                      drain_flags[i][0], 1'b1, 1'b0);
        end
        chk("drain_last_rdata", 32'(rdata_s), 32'h44);

        op(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("underflow", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("underflow_rdata_hold", 32'(rdata_s), 32'h44);

        op(1'b0, 8'h00, 1'b0, 1'b1);
        chk_state("clr_err", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) op(1'b1, fill_b[i], 1'b0, 1'b0);
        chk_state("refill", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        op(1'b1, 8'h99, 1'b0, 1'b1);
        chk_state("set_beats_clr", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        op(1'b0, 8'h00, 1'b0, 1'b1);
        chk_state("clr_again", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        op(1'b0, 8'h00, 1'b1, 1'b0);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("to_two", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            op(1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
            chk_state("pushpop", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        op(1'b0, 8'h00, 1'b1, 1'b0);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("empty_again", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_last_rdata", 32'(rdata_s), 32'h83);

        op(1'b1, 8'hA5, 1'b0, 1'b0);
        chk_state("fwft_push", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fwft_head_no_pop", 32'(rdata_f), 32'hA5);
        chk("std_holds_no_pop", 32'(rdata_s), 32'h83);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("fwft_pop", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        op(1'b1, 8'hB6, 1'b1, 1'b0);
        chk_state("pushpop_empty", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("pushpop_empty_fwft", 32'(rdata_f), 32'hB6);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("final_pop", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        op(1'b0, 8'h00, 1'b0, 1'b0);
        chk("std_outstanding", 32'(exp_q.size()), 32'h0);
        chk("model_outstanding", 32'(m_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
